// File: rtl/reset_sequencer.sv
// reset_sequencer: holds NUM_CH reset channels asserted for a qualifying
// hold period, releases them one after another STAGGER cycles apart, then
// counts run cycles with an optional run limit that re-asserts everything.
module reset_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int HOLD_CYCLES = 10,
   parameter int STAGGER     = 2,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_rst,
   input  logic              limit_en,
   output logic [NUM_CH-1:0] rst_out,
   output logic              all_released,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic              timeout
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [STG_W-1:0]  STG_LAST  = STG_W'((STAGGER > 0) ? STAGGER - 1 : 0);
   localparam logic [STG_W-1:0]  STG_ZERO  = STG_W'(0);
   localparam logic [STG_W-1:0]  STG_ONE   = STG_W'(1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [CH_W-1:0]   CH_ZERO   = CH_W'(0);
   localparam logic [CH_W-1:0]   CH_ONE    = CH_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [NUM_CH-1:0] CH_ALL1   = {NUM_CH{1'b1}};
   localparam logic [NUM_CH-1:0] CH_ALL0   = {NUM_CH{1'b0}};
   // Single-channel or zero-stagger configurations release everything at once
   localparam bit DIRECT_RUN = (NUM_CH == 1) || (STAGGER == 0);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   logic [1:0]        r_sync;
   logic              w_sync_rst;
   state_t            r_state,   w_state;
   logic [HOLD_W-1:0] r_hold,    w_hold;
   logic [STG_W-1:0]  r_stg,     w_stg;
   logic [CH_W-1:0]   r_ch,      w_ch;
   logic [NUM_CH-1:0] r_rst_out, w_rst_out;
   logic              r_all,     w_all;
   logic [CNT_W-1:0]  r_cnt,     w_cnt;
   logic              r_to,      w_to;
   logic [CNT_W-1:0]  w_cnt_inc;

   // Reset synchronizer: asserts at once, releases after two clean edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], 1'b0};
      end
   end

   assign w_sync_rst = r_sync[1];
   // Run counter saturates instead of wrapping
   assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

   // Next-state and next-output logic; soft_rst overrides every state
   always_comb begin
      w_state   = r_state;
      w_hold    = r_hold;
      w_stg     = r_stg;
      w_ch      = r_ch;
      w_rst_out = r_rst_out;
      w_all     = r_all;
      w_cnt     = r_cnt;
      w_to      = r_to;
      if (soft_rst) begin
         w_state   = ST_HOLD;
         w_hold    = HOLD_ZERO;
         w_stg     = STG_ZERO;
         w_ch      = CH_ZERO;
         w_rst_out = CH_ALL1;
         w_all     = 1'b0;
         w_cnt     = CNT_ZERO;
         w_to      = 1'b0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (w_sync_rst) begin
                  w_hold = HOLD_ZERO;
               end else if (r_hold == HOLD_LAST) begin
                  w_hold = HOLD_ZERO;
                  if (DIRECT_RUN) begin
                     w_rst_out = CH_ALL0;
                     w_all     = 1'b1;
                     w_cnt     = CNT_ZERO;
                     w_state   = ST_RUN;
                  end else begin
                     w_rst_out[0] = 1'b0;
                     w_stg        = STG_ZERO;
                     w_ch         = CH_ONE;
                     w_state      = ST_RELEASE;
                  end
               end else begin
                  w_hold = r_hold + HOLD_ONE;
               end
            end
            ST_RELEASE: begin
               if (r_stg == STG_LAST) begin
                  w_stg = STG_ZERO;
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (CH_W'(k) == r_ch) begin
                        w_rst_out[k] = 1'b0;
                     end else begin
                        w_rst_out[k] = r_rst_out[k];
                     end
                  end
                  if (r_ch == CH_LAST) begin
                     w_all   = 1'b1;
                     w_cnt   = CNT_ZERO;
                     w_state = ST_RUN;
                  end else begin
                     w_ch = r_ch + CH_ONE;
                  end
               end else begin
                  w_stg = r_stg + STG_ONE;
               end
            end
            ST_RUN: begin
               if (limit_en && (r_cnt >= CNT_LIMIT)) begin
                  // limit enabled late with the count already past it
                  w_state   = ST_DONE;
                  w_rst_out = CH_ALL1;
                  w_all     = 1'b0;
                  w_to      = 1'b1;
               end else begin
                  w_cnt = w_cnt_inc;
                  if (limit_en && (w_cnt_inc == CNT_LIMIT)) begin
                     w_state   = ST_DONE;
                     w_rst_out = CH_ALL1;
                     w_all     = 1'b0;
                     w_to      = 1'b1;
                  end else begin
                     w_state = ST_RUN;
                  end
               end
            end
            ST_DONE: begin
               w_state = ST_DONE;
            end
            default: begin
               w_state   = ST_HOLD;
               w_hold    = HOLD_ZERO;
               w_stg     = STG_ZERO;
               w_ch      = CH_ZERO;
               w_rst_out = CH_ALL1;
               w_all     = 1'b0;
               w_cnt     = CNT_ZERO;
               w_to      = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; rst asserts every channel immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_HOLD;
         r_hold    <= HOLD_ZERO;
         r_stg     <= STG_ZERO;
         r_ch      <= CH_ZERO;
         r_rst_out <= CH_ALL1;
         r_all     <= 1'b0;
         r_cnt     <= CNT_ZERO;
         r_to      <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_hold    <= w_hold;
         r_stg     <= w_stg;
         r_ch      <= w_ch;
         r_rst_out <= w_rst_out;
         r_all     <= w_all;
         r_cnt     <= w_cnt;
         r_to      <= w_to;
      end
   end

   assign rst_out      = r_rst_out;
   assign all_released = r_all;
   assign cycle_cnt    = r_cnt;
   assign timeout      = r_to;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: four configurations driven by shared reset
// stimulus, checked every cycle against an edge-counting reference model
// plus hand-computed checkpoints.
module tb_reset_sequencer;

   localparam int NI   = 4;
   localparam int HOLD = 10;

   // Instance configurations: A default, B 1ch/0 stagger, C 4ch/0 stagger, D 4-bit counter
   int p_nch  [NI] = '{4, 1, 4, 4};
   int p_stg  [NI] = '{2, 0, 0, 2};
   int p_cmax [NI] = '{65535, 65535, 65535, 15};
   int p_to   [NI] = '{50, 50, 50, 10};

   logic          clk = 1'b0;
   bit            clk_run = 1'b1;
   logic          rst = 1'b0;
   logic          soft_rst = 1'b0;
   logic [NI-1:0] lim = 4'b0000;

   logic [3:0]  a_out, c_out, d_out;
   logic [0:0]  b_out;
   logic [15:0] a_cnt, b_cnt, c_cnt;
   logic [3:0]  d_cnt;
   logic        a_all, b_all, c_all, d_all;
   logic        a_to, b_to, c_to, d_to;

   logic [31:0] g_out [NI];
   logic [31:0] g_cnt [NI];
   logic [NI-1:0] g_all, g_to;

   int          m_since;
   int          m_k    [NI];
   int          m_cnt  [NI];
   bit          m_done [NI];
   logic [31:0] e_out  [NI];
   logic [31:0] e_cnt  [NI];
   logic [NI-1:0] e_all, e_to;

   int n_vec = 0;
   int n_err = 0;

   reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(10), .STAGGER(2), .CNT_W(16), .TIMEOUT(50)) u_a (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .limit_en(lim[0]),
      .rst_out(a_out), .all_released(a_all), .cycle_cnt(a_cnt), .timeout(a_to));
   reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(10), .STAGGER(0), .CNT_W(16), .TIMEOUT(50)) u_b (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .limit_en(lim[1]),
      .rst_out(b_out), .all_released(b_all), .cycle_cnt(b_cnt), .timeout(b_to));
   reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(10), .STAGGER(0), .CNT_W(16), .TIMEOUT(50)) u_c (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .limit_en(lim[2]),
      .rst_out(c_out), .all_released(c_all), .cycle_cnt(c_cnt), .timeout(c_to));
   reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(10), .STAGGER(2), .CNT_W(4), .TIMEOUT(10)) u_d (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .limit_en(lim[3]),
      .rst_out(d_out), .all_released(d_all), .cycle_cnt(d_cnt), .timeout(d_to));

   // Clock generator with a gate so the clock can be stopped
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // Collect the four instances into uniform arrays
   always_comb begin
      g_out[0] = {28'd0, a_out};
      g_out[1] = {31'd0, b_out};
      g_out[2] = {28'd0, c_out};
      g_out[3] = {28'd0, d_out};
      g_cnt[0] = {16'd0, a_cnt};
      g_cnt[1] = {16'd0, b_cnt};
      g_cnt[2] = {16'd0, c_cnt};
      g_cnt[3] = {28'd0, d_cnt};
      g_all    = {d_all, c_all, b_all, a_all};
      g_to     = {d_to, c_to, b_to, a_to};
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: k counts qualifying edges since the last clear;
   // channel c is released once k reaches HOLD + c*STAGGER
   always @(posedge clk or posedge rst) begin
      bit qual;
      int last;
      if (rst) begin
         m_since = 0;
         for (int i = 0; i < NI; i++) begin
            m_k[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0;
         end
      end else begin
         qual = (m_since >= 2) && !soft_rst;
         if (m_since < 2) m_since++;
         for (int i = 0; i < NI; i++) begin
            last = HOLD + (p_nch[i] - 1) * p_stg[i];
            if (soft_rst) begin
               m_k[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0;
            end else if (!m_done[i]) begin
               if (m_k[i] >= last) begin
                  if (lim[i] && m_cnt[i] >= p_to[i]) begin
                     m_done[i] = 1'b1;
                  end else begin
                     if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
                     if (lim[i] && m_cnt[i] == p_to[i]) m_done[i] = 1'b1;
                  end
               end else if (qual) begin
                  m_k[i]++;
                  if (m_k[i] == last) m_cnt[i] = 0;
               end
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         last = HOLD + (p_nch[i] - 1) * p_stg[i];
         if (m_done[i]) begin
            e_out[i] = (32'd1 << p_nch[i]) - 32'd1;
            e_all[i] = 1'b0;
            e_to[i]  = 1'b1;
         end else begin
            e_out[i] = 32'd0;
            for (int c = 0; c < p_nch[i]; c++) begin
               if (m_k[i] < HOLD + c * p_stg[i]) e_out[i][c] = 1'b1;
            end
            e_all[i] = (m_k[i] >= last);
            e_to[i]  = 1'b0;
         end
         e_cnt[i] = m_cnt[i];
      end
   end

   // Per-cycle comparison of every instance against the model
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("dut%0d.rst_out", i), g_out[i], e_out[i]);
         chk($sformatf("dut%0d.all_released", i), {31'd0, g_all[i]}, {31'd0, e_all[i]});
         chk($sformatf("dut%0d.cycle_cnt", i), g_cnt[i], e_cnt[i]);
         chk($sformatf("dut%0d.timeout", i), {31'd0, g_to[i]}, {31'd0, e_to[i]});
      end
   end

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Directed stimulus with hand-computed checkpoints on instance A (and B/C/D)
   initial begin
      lim = 4'b0001;
      #1 rst = 1'b1;
      #1;
      chk("reset rst_out", g_out[0], 32'hF);
      chk("reset all", {31'd0, a_all}, 32'd0);
      chk("reset cnt", g_cnt[0], 32'd0);
      chk("reset timeout", {31'd0, a_to}, 32'd0);
      adv(10);
      rst = 1'b0;                       // S is the third edge after this
      adv(11);                          // after S+8
      chk("S+8 rst_out", g_out[0], 32'hF);
      adv(1);                           // after S+9
      chk("S+9 rst_out", g_out[0], 32'hE);
      chk("S+9 B rst_out", g_out[1], 32'h0);
      chk("S+9 B all", {31'd0, b_all}, 32'd1);
      chk("S+9 C rst_out", g_out[2], 32'h0);
      chk("S+9 C all", {31'd0, c_all}, 32'd1);
      adv(2);                           // after S+11
      chk("S+11 rst_out", g_out[0], 32'hC);
      adv(4);                           // after S+15
      chk("S+15 rst_out", g_out[0], 32'h0);
      chk("S+15 all", {31'd0, a_all}, 32'd1);
      chk("S+15 cnt", g_cnt[0], 32'd0);
      chk("S+15 C cnt", g_cnt[2], 32'd6);
      adv(49);                          // after S+64
      chk("S+64 cnt", g_cnt[0], 32'd49);
      chk("S+64 timeout", {31'd0, a_to}, 32'd0);
      adv(1);                           // after S+65
      chk("S+65 cnt", g_cnt[0], 32'd50);
      chk("S+65 timeout", {31'd0, a_to}, 32'd1);
      chk("S+65 rst_out", g_out[0], 32'hF);
      chk("S+65 all", {31'd0, a_all}, 32'd0);
      chk("S+65 B cnt", g_cnt[1], 32'd56);
      chk("S+65 D cnt", g_cnt[3], 32'd15);
      adv(5);                           // after S+70
      chk("S+70 cnt held", g_cnt[0], 32'd50);
      chk("S+70 D cnt sat", g_cnt[3], 32'd15);
      chk("S+70 D timeout", {31'd0, d_to}, 32'd0);

      // soft reset clears timeout and restarts; pulse again mid-release
      soft_rst = 1'b1;
      adv(1);
      soft_rst = 1'b0;
      chk("soft rst_out", g_out[0], 32'hF);
      chk("soft timeout", {31'd0, a_to}, 32'd0);
      chk("soft cnt", g_cnt[0], 32'd0);
      adv(12);                          // after S0+11
      chk("S0+11 rst_out", g_out[0], 32'hC);
      soft_rst = 1'b1;
      adv(1);                           // soft edge at S0+12
      soft_rst = 1'b0;
      chk("S0+12 rst_out", g_out[0], 32'hF);
      adv(9);                           // after S0+21
      chk("S0+21 rst_out", g_out[0], 32'hF);
      adv(1);                           // after S0+22
      chk("S0+22 rst_out", g_out[0], 32'hE);
      adv(21);                          // after S'+30, in RUN
      chk("S'+30 cnt", g_cnt[0], 32'd15);

      // asynchronous reset with the clock stopped
      clk_run = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async rst_out", g_out[0], 32'hF);
      chk("async cnt", g_cnt[0], 32'd0);
      chk("async all", {31'd0, a_all}, 32'd0);
      chk("async D rst_out", g_out[3], 32'hF);
      #2 rst = 1'b0;
      lim[0] = 1'b0;
      #2 clk_run = 1'b1;

      // late limit enable with count already past TIMEOUT
      adv(1 + 2 + 15 + 60);             // after S+75
      chk("late cnt", g_cnt[0], 32'd60);
      chk("late timeout pre", {31'd0, a_to}, 32'd0);
      lim[0] = 1'b1;
      adv(1);
      chk("late timeout", {31'd0, a_to}, 32'd1);
      chk("late rst_out", g_out[0], 32'hF);
      chk("late cnt frozen", g_cnt[0], 32'd60);

      // soft reset held for several cycles
      soft_rst = 1'b1;
      adv(3);
      chk("held soft rst_out", g_out[0], 32'hF);
      chk("held soft timeout", {31'd0, a_to}, 32'd0);
      chk("held soft cnt", g_cnt[0], 32'd0);
      soft_rst = 1'b0;
      adv(10);                          // after S+9
      chk("resume S+9 rst_out", g_out[0], 32'hE);
      adv(6);                           // after S+15
      chk("resume S+15 all", {31'd0, a_all}, 32'd1);
      adv(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
